// File: rtl/vpu_sprite_ram_arbiter.sv
// Sprite RAM arbiter: the VPU loader owns the port whenever vpu_en is high; the CPU borrows idle
// cycles through a req/ack handshake (grant cycle, then ack cycle), with a sticky starvation flag.
module vpu_sprite_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vpu_en,
  input  logic [ADDR_W-1:0]   vpu_addr,
  output logic [DATA_W-1:0]   vpu_dout,
  output logic                vpu_valid,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_starved,
  input  logic                status_clr,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              grant;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              starved_q, starved_d;
  logic              vpu_valid_q;

  assign grant = (state_q == S_IDLE) && cpu_req && !vpu_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      rdata_q     <= '0;
      wait_q      <= '0;
      starved_q   <= 1'b0;
      vpu_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
      starved_q   <= starved_d;
      vpu_valid_q <= vpu_en;
    end
  end

  // Never grant in ACK: this forces the dead cycle between CPU accesses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    starved_d = starved_q;
    if (grant) rd_d = !cpu_we;
    if (state_q == S_ACK && rd_q) rdata_d = ram_dout;
    if (grant || !cpu_req) begin
      wait_d = '0;
    end else if (state_q == S_IDLE && vpu_en && wait_q != LIMIT) begin
      wait_d = wait_q + CNT_W'(1);
    end
    // Set has priority over a coincident clear.
    if (status_clr) starved_d = 1'b0;
    if (wait_d == LIMIT) starved_d = 1'b1;
  end

  always_comb begin
    cpu_ack     = (state_q == S_ACK);
    cpu_rdata   = (cpu_ack && rd_q) ? ram_dout : rdata_q;
    cpu_starved = starved_q;
    vpu_valid   = vpu_valid_q;
    vpu_dout    = ram_dout;
    ram_din     = cpu_wdata;
    ram_en      = 1'b0;
    ram_we      = '0;
    ram_addr    = vpu_addr;
    if (vpu_en) begin
      ram_en   = 1'b1;
    end else if (grant) begin
      ram_en   = 1'b1;
      ram_addr = cpu_addr;
      ram_we   = cpu_we ? cpu_be : {BE_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_vpu_sprite_ram_arbiter.sv
// Bench for vpu_sprite_ram_arbiter: sprite RAM model, scoreboard memory and cycle-level
// reference of the arbitration rules, driven by directed scenarios and random traffic.
module tb_vpu_sprite_ram_arbiter;

  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vpu_en, cpu_req, cpu_we, status_clr;
  logic [9:0]  vpu_addr, cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] vpu_dout, cpu_rdata, ram_din, ram_dout;
  logic        vpu_valid, cpu_ack, cpu_starved, ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;

  always #5 clk = ~clk;

  vpu_sprite_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .vpu_en(vpu_en), .vpu_addr(vpu_addr), .vpu_dout(vpu_dout), .vpu_valid(vpu_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_starved(cpu_starved),
    .status_clr(status_clr), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM, 1-cycle read latency; port values are sampled mid-cycle.
  logic [31:0] ram_mem [1024];
  logic        s_en;
  logic [3:0]  s_we;
  logic [9:0]  s_addr;
  logic [31:0] s_din;

  always @(posedge clk) begin
    if (s_en) begin
      for (int b = 0; b < 4; b++)
        if (s_we[b]) ram_mem[s_addr][8*b +: 8] <= s_din[8*b +: 8];
      ram_dout <= ram_mem[s_addr];
    end
  end

  // Reference state
  logic [31:0] ref_mem [1024];
  bit          m_ack, m_ack_rd, m_starved, m_prev_vpu;
  logic [31:0] m_rd_exp;
  int          m_wait;
  bit          last_ack;
  logic [31:0] last_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ack = 0; m_ack_rd = 0; m_starved = 0; m_prev_vpu = 0; m_wait = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    bit grant, was_ack;
    @(negedge clk);
    was_ack = m_ack;
    grant   = !m_ack && cpu_req && !vpu_en;
    check("ack", cpu_ack, m_ack);
    if (m_ack && m_ack_rd) check("rdata", cpu_rdata, m_rd_exp);
    check("vpu_valid", vpu_valid, m_prev_vpu);
    check("vpu_dout", vpu_dout, ram_dout);
    check("ram_en", ram_en, vpu_en | grant);
    if (vpu_en) begin
      check("ram_addr_vpu", ram_addr, vpu_addr);
      check("ram_we_vpu", ram_we, 0);
    end else if (grant) begin
      check("ram_addr_cpu", ram_addr, cpu_addr);
      check("ram_we_cpu", ram_we, cpu_we ? cpu_be : 4'h0);
      if (cpu_we) check("ram_din", ram_din, cpu_wdata);
    end else begin
      check("ram_we_idle", ram_we, 0);
    end
    check("starved", cpu_starved, m_starved);
    last_ack   = m_ack;
    last_rdata = cpu_rdata;

    if (grant) begin
      if (cpu_we) begin
        for (int b = 0; b < 4; b++)
          if (cpu_be[b]) ref_mem[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
      end else begin
        m_rd_exp = ref_mem[cpu_addr];
      end
      m_ack_rd = !cpu_we;
    end
    m_ack = grant;
    if (grant || !cpu_req) m_wait = 0;
    else if (!was_ack && vpu_en && m_wait < LIMIT) m_wait++;
    if (m_wait == LIMIT) m_starved = 1;
    else if (status_clr) m_starved = 0;
    m_prev_vpu = vpu_en;
    s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_din = ram_din;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input bit drop, output int n);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_ack && n < 300);
    if (!last_ack) check("ack_timeout", last_ack, 1);
    if (drop) cpu_req = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
    ram_dout = '0;
    s_en = 0; s_we = '0; s_addr = '0; s_din = '0;
    rst_n = 0; vpu_en = 0; vpu_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
    cpu_wdata = '0; cpu_be = '0; status_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", cpu_ack, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_starved", cpu_starved, 0);
    check("rst_vpu_valid", vpu_valid, 0);
    rst_n = 1;
    cycle();

    // Write then read back, VPU idle
    cpu_access(1, 10'h280, 32'hDEADBEEF, 4'hF, 1, n);
    check("wr_latency", n, 2);
    cpu_access(0, 10'h280, '0, 4'h0, 1, n);
    check("rd_latency", n, 2);
    check("rd_deadbeef", last_rdata, 32'hDEADBEEF);

    // VPU burst of 20 reads while a CPU read is pending
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
    n = 0;
    do begin
      vpu_en   = (n < 20);
      vpu_addr = 10'(640 + n);
      cycle();
      n++;
    end while (!last_ack && n < 100);
    check("vpu_burst_ack_cycle", n, 22);
    cpu_req = 0; vpu_en = 0;

    // Back-to-back reads with cpu_req held high
    for (int i = 0; i < 6; i++) begin
      cpu_access(0, 10'(i * 97), '0, 4'h0, (i == 5), n);
      check("b2b_latency", n, 2);
    end

    // Partial byte-enable write
    cpu_access(1, 10'h155, 32'h11223344, 4'hF, 1, n);
    cpu_access(1, 10'h155, 32'hAABBCCDD, 4'h3, 1, n);
    cpu_access(0, 10'h155, '0, 4'h0, 1, n);
    check("be_merge", last_rdata, 32'h1122CCDD);
    cpu_access(1, 10'h155, 32'h55555555, 4'h0, 1, n);
    check("be_zero_latency", n, 2);
    cpu_access(0, 10'h155, '0, 4'h0, 1, n);
    check("be_zero_keep", last_rdata, 32'h1122CCDD);

    // Starvation: 70 cycles of VPU traffic with a CPU read pending
    vpu_en = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h020;
    for (int i = 0; i < 70; i++) begin
      vpu_addr = 10'(i);
      cycle();
      if (i == 62) check("starve_63", cpu_starved, 0);
      if (i == 63) check("starve_64", cpu_starved, 1);
    end
    vpu_en = 0;
    cpu_access(0, 10'h020, '0, 4'h0, 1, n);
    check("starve_sticky", cpu_starved, 1);
    status_clr = 1; cycle(); status_clr = 0;
    check("starve_clr", cpu_starved, 0);
    // Clear coincides with the set cycle
    vpu_en = 1; cpu_req = 1;
    for (int i = 0; i < 63; i++) cycle();
    check("starve_pre_set", cpu_starved, 0);
    status_clr = 1; cycle(); status_clr = 0;
    check("set_wins", cpu_starved, 1);
    vpu_en = 0;
    cpu_access(0, 10'h020, '0, 4'h0, 1, n);
    status_clr = 1; cycle(); status_clr = 0;

    // Asynchronous reset during the ACK cycle of a write
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h124; cpu_wdata = 32'hCAFEF00D; cpu_be = 4'hF;
    cycle();
    check("rst_pre_ack", cpu_ack, 1);
    #2 rst_n = 0;
    #1 check("rst_ack_drop", cpu_ack, 0);
    cpu_req = 0; s_en = 0;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    check("rst_mid_starved", cpu_starved, 0);
    cycle();
    cpu_access(0, 10'h124, '0, 4'h0, 1, n);
    check("rst_reissue_latency", n, 2);
    check("rst_write_committed", last_rdata, 32'hCAFEF00D);

    // Random traffic with varying VPU load
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = (blk == 3) ? 100 : int'($urandom_range(0, 90));
      for (int c = 0; c < 400; c++) begin
        vpu_en     = ($urandom_range(0, 99) < dens);
        vpu_addr   = 10'($urandom);
        status_clr = ($urandom_range(0, 49) == 0);
        if (!cpu_req && $urandom_range(0, 2) == 0) begin
          cpu_req   = 1;
          cpu_we    = 1'($urandom);
          cpu_addr  = $urandom_range(0, 1) ? 10'($urandom_range(0, 7)) : 10'($urandom);
          cpu_wdata = $urandom;
          cpu_be    = 4'($urandom);
        end
        cycle();
        if (last_ack) begin
          if ($urandom_range(0, 1) == 0) begin
            cpu_req = 0;
          end else begin
            cpu_we    = 1'($urandom);
            cpu_addr  = 10'($urandom_range(0, 7));
            cpu_wdata = $urandom;
            cpu_be    = 4'($urandom);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
